decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/core_pkg.sv | 53 +++++
 rtl/decode_lut.sv | 60 ++++++
 rtl/decode_ctrl.sv | 123 ++++++++++++
 tb/tb_decode_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode types: opcode classes, func3 sub-encodings, result/immediate selects and the control bundle.
// Consumed by decode_lut and decode_ctrl (vector sequencing gated by DECODE_CTRL_VEC_EN).
package core_pkg;

  typedef enum logic [2:0] {
    OP_A = 3'b000,
    OP_B = 3'b001,
    OP_C = 3'b010,
    OP_D = 3'b011,
    OP_E = 3'b100,
    OP_F = 3'b101,
    OP_G = 3'b110,
    OP_H = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    D_F3_LINK = 3'b000,
    D_F3_REG  = 3'b001
  } d_func3_e;

  typedef enum logic [2:0] {
    F_F3_MEM = 3'b000
  } f_func3_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  localparam logic [3:0] IMM_NONE     = 4'b0000;
  localparam logic [3:0] IMM_B_HI     = 4'b0010;
  localparam logic [3:0] IMM_STORE    = 4'b0100;
  localparam logic [3:0] IMM_JUMP     = 4'b1100;
  localparam logic [3:0] IMM_JUMP_REG = 4'b1110;

  localparam logic [2:0] ALU_BRANCH = 3'b001;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        jump_cond;
    logic        alu_src;
    logic [2:0]  jump_cond_type;
    logic [2:0]  alu_control;
    logic [3:0]  imm_src;
    result_src_e result_src;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_lut.sv
// Pure combinational field-to-control lookup for one instruction.
// With DECODE_CTRL_VEC_EN defined, OP_E decodes as a vector op; otherwise it is illegal.
module decode_lut
  import core_pkg::*;
(
  input  logic [2:0] op,
  input  logic [2:0] func3,
  output ctrl_t      ctrl,
  output logic       is_vec
);

  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    ctrl                = '0;
    is_vec              = 1'b0;
    ctrl.reg_write      = 1'b1;
    ctrl.jump_cond_type = func3;
    case (op)
      OP_A: ctrl.alu_control = func3;
      OP_B: begin
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = func3;
        ctrl.imm_src     = func3[2] ? IMM_B_HI : IMM_NONE;
      end
      OP_C: begin
        ctrl.reg_write = 1'b0;
        ctrl.mem_write = 1'b1;
        ctrl.imm_src   = IMM_STORE;
      end
      OP_D: begin
        ctrl.jump       = 1'b1;
        ctrl.imm_src    = (func3 == D_F3_REG) ? IMM_JUMP_REG : IMM_JUMP;
        ctrl.result_src = (func3 == D_F3_LINK || func3 == D_F3_REG) ? RES_IMM : RES_PC4;
      end
      OP_F: begin
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = (func3 == F_F3_MEM) ? RES_MEM : RES_PC4;
      end
      OP_G: begin
        ctrl.reg_write   = 1'b0;
        ctrl.jump_cond   = 1'b1;
        ctrl.alu_control = ALU_BRANCH;
        ctrl.imm_src     = IMM_JUMP;
      end
`ifdef DECODE_CTRL_VEC_EN
      OP_E: begin
        ctrl.jump_cond_type = '0;
        ctrl.alu_control    = func3;
        is_vec              = 1'b1;
      end
`endif
      default: begin
        ctrl         = '0;
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Registered instruction decoder with IDLE/HOLD/VEC handshake sequencing and flush.
// Vector beat sequencing is available only when DECODE_CTRL_VEC_EN is defined.
module decode_ctrl
  import core_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        op,
  input  logic [2:0]        func3,
  input  logic [10:0]       func11,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic              reg_write,
  output logic              mem_write,
  output logic              jump,
  output logic              jump_cond,
  output logic              alu_src,
  output logic [2:0]        jump_cond_type,
  output logic [2:0]        alu_control,
  output logic [3:0]        imm_src,
  output logic [1:0]        result_src,
  output logic              illegal,
  output logic [LANE_W-1:0] lane_idx,
  output logic              lane_last
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_VEC} state_e;

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [LANE_W-1:0] lane_idx_q, lane_idx_d;
  logic              lane_last_q, lane_last_d;

  ctrl_t             dec_ctrl;
  logic              dec_is_vec;
  logic              accept;
  logic [LANE_W-1:0] lane_next;

  // func11 carries no control information for this op set.
  logic unused_func11;
  assign unused_func11 = ^func11;

  decode_lut u_decode_lut (
    .op     (op),
    .func3  (func3),
    .ctrl   (dec_ctrl),
    .is_vec (dec_is_vec)
  );

  assign lane_next = lane_idx_q + LANE_W'(1);

  always_comb begin
    in_ready    = !flush && (state_q == ST_IDLE || (state_q == ST_HOLD && out_ready));
    accept      = in_valid && in_ready;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    lane_idx_d  = lane_idx_q;
    lane_last_d = lane_last_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      lane_idx_d  = '0;
    end else if (accept) begin
      // A HOLD accept implies out_ready, so the held beat leaves as the new one loads.
      state_d     = dec_is_vec ? ST_VEC : ST_HOLD;
      out_valid_d = 1'b1;
      ctrl_d      = dec_ctrl;
      lane_idx_d  = '0;
      lane_last_d = !dec_is_vec;
    end else if (out_valid_q && out_ready) begin
      if (state_q == ST_VEC && lane_idx_q != LANE_LAST) begin
        lane_idx_d  = lane_next;
        lane_last_d = (lane_next == LANE_LAST);
      end else begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        lane_idx_d  = '0;
      end
    end
  end

  // NOTE: reset is synchronous and sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      lane_idx_q  <= '0;
      lane_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      lane_idx_q  <= lane_idx_d;
      lane_last_q <= lane_last_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign reg_write      = ctrl_q.reg_write;
  assign mem_write      = ctrl_q.mem_write;
  assign jump           = ctrl_q.jump;
  assign jump_cond      = ctrl_q.jump_cond;
  assign alu_src        = ctrl_q.alu_src;
  assign jump_cond_type = ctrl_q.jump_cond_type;
  assign alu_control    = ctrl_q.alu_control;
  assign imm_src        = ctrl_q.imm_src;
  assign result_src     = ctrl_q.result_src;
  assign illegal        = ctrl_q.illegal;
  assign lane_idx       = lane_idx_q;
  assign lane_last      = lane_last_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed scenarios then randomized traffic against a
// queue-of-expected-beats model. Follows DECODE_CTRL_VEC_EN the same way the design does.
module tb_decode_ctrl;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;
`ifdef DECODE_CTRL_VEC_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]        op, func3;
  logic [10:0]       func11;
  logic              reg_write, mem_write, jump, jump_cond, alu_src, illegal, lane_last;
  logic [2:0]        jump_cond_type, alu_control;
  logic [3:0]        imm_src;
  logic [1:0]        result_src;
  logic [LANE_W-1:0] lane_idx;

  always #5 clk = ~clk;

  decode_ctrl #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func11(func11),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .reg_write(reg_write), .mem_write(mem_write), .jump(jump),
    .jump_cond(jump_cond), .alu_src(alu_src), .jump_cond_type(jump_cond_type),
    .alu_control(alu_control), .imm_src(imm_src), .result_src(result_src),
    .illegal(illegal), .lane_idx(lane_idx), .lane_last(lane_last)
  );

  typedef struct {
    logic [17:0] ctrl;
    int          lane;
    bit          last;
    bit          vec;
  } beat_t;

  beat_t pend[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected control bundle written straight from the decode table.
  function automatic logic [17:0] model_ctrl(input int o, input int f3);
    bit rw = 1'b1, mw = 1'b0, j = 1'b0, jc = 1'b0, as = 1'b0, ill = 1'b0;
    int jct = f3, alu = 0, imm = 0, res = 0;
    if (o == 0) alu = f3;
    else if (o == 1) begin as = 1'b1; alu = f3; imm = (f3 >= 4) ? 2 : 0; end
    else if (o == 2) begin rw = 1'b0; mw = 1'b1; imm = 4; end
    else if (o == 3) begin j = 1'b1; imm = (f3 == 1) ? 14 : 12; res = (f3 <= 1) ? 3 : 2; end
    else if (o == 5) begin j = 1'b1; as = 1'b1; res = (f3 == 0) ? 1 : 2; end
    else if (o == 6) begin rw = 1'b0; jc = 1'b1; alu = 1; imm = 12; end
    else if (o == 4 && VEC) begin jct = 0; alu = f3; end
    else begin rw = 1'b0; jct = 0; ill = 1'b1; end
    return {rw, mw, j, jc, as, 3'(jct), 3'(alu), 4'(imm), 2'(res), ill};
  endfunction

  function automatic logic [17:0] dut_ctrl();
    return {reg_write, mem_write, jump, jump_cond, alu_src, jump_cond_type,
            alu_control, imm_src, result_src, illegal};
  endfunction

  function automatic bit exp_in_ready(input bit fl, input bit ordy);
    return !fl && (pend.size() == 0 || (pend.size() == 1 && !pend[0].vec && ordy));
  endfunction

  task automatic check_outputs(input bit was_reset, input bit was_flush);
    check("out_valid", out_valid, pend.size() != 0);
    if (was_reset) begin
      check("rst_ctrl", dut_ctrl(), 0);
      check("rst_lane_idx", lane_idx, 0);
      check("rst_lane_last", lane_last, 0);
    end
    if (was_flush) check("flush_lane_idx", lane_idx, 0);
    if (pend.size() != 0) begin
      check("ctrl", dut_ctrl(), pend[0].ctrl);
      check("lane_idx", lane_idx, pend[0].lane);
      check("lane_last", lane_last, pend[0].last);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance the model, then check registered outputs.
  task automatic cycle(input bit r, input bit fl, input bit iv, input int o, input int f3,
                       input bit ordy);
    bit    ir;
    beat_t b;
    rst_n = r; flush = fl; in_valid = iv; op = 3'(o); func3 = 3'(f3);
    func11 = 11'($urandom); out_ready = ordy;
    #1;
    ir = exp_in_ready(fl, ordy);
    if (r) check("in_ready", in_ready, ir);
    if (!r || fl) pend.delete();
    else begin
      if (pend.size() > 0 && ordy) void'(pend.pop_front());
      if (iv && ir) begin
        if (o == 4 && VEC) begin
          for (int i = 0; i < LANES; i++) begin
            b.ctrl = model_ctrl(o, f3); b.lane = i; b.last = (i == LANES - 1); b.vec = 1'b1;
            pend.push_back(b);
          end
        end else begin
          b.ctrl = model_ctrl(o, f3); b.lane = 0; b.last = 1'b1; b.vec = 1'b0;
          pend.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs(!r, fl && r);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; func3 = '0; func11 = '0;
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Scalar B-type decode.
    cycle(1, 0, 1, 1, 5, 1);
    check("b_alu_control", alu_control, 3'b101);
    check("b_imm_src", imm_src, 4'b0010);
    check("b_alu_src", alu_src, 1'b1);
    check("b_reg_write", reg_write, 1'b1);
    check("b_result_src", result_src, 2'b00);
    cycle(1, 0, 0, 0, 0, 1);

    // Store held under backpressure.
    cycle(1, 0, 1, 2, 3, 0);
    repeat (3) begin
      cycle(1, 0, 1, 0, 0, 0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_mem_write", mem_write, 1'b1);
      check("bp_imm_src", imm_src, 4'b0100);
      check("bp_in_ready", in_ready, 1'b0);
    end
    cycle(1, 0, 0, 0, 0, 1);

    // OP_E: vector beats or a single illegal beat.
    cycle(1, 0, 1, 4, 3, 1);
`ifdef DECODE_CTRL_VEC_EN
    for (int k = 0; k < LANES; k++) begin
      check("vec_lane_idx", lane_idx, k);
      check("vec_lane_last", lane_last, k == LANES - 1);
      check("vec_in_ready", in_ready, 1'b0);
      cycle(1, 0, 0, 0, 0, 1);
    end
    check("vec_done_valid", out_valid, 1'b0);
    check("vec_done_ready", in_ready, 1'b1);
`else
    check("e_illegal", illegal, 1'b1);
    check("e_reg_write", reg_write, 1'b0);
    cycle(1, 0, 0, 0, 0, 1);
    check("e_single_beat", out_valid, 1'b0);
`endif

    // Flush part-way through an OP_E sequence.
    cycle(1, 0, 1, 4, 6, 1);
    cycle(1, 0, 0, 0, 0, 1);
`ifdef DECODE_CTRL_VEC_EN
    check("mid_lane_idx", lane_idx, 1);
`endif
    cycle(1, 1, 1, 1, 0, 1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_idx", lane_idx, 0);
    cycle(1, 0, 0, 0, 0, 1);
    check("post_flush_ready", in_ready, 1'b1);

    // Illegal op, left held, then reset while holding.
    cycle(1, 0, 1, 7, 2, 0);
    check("h_illegal", illegal, 1'b1);
    check("h_reg_write", reg_write, 1'b0);
    check("h_out_valid", out_valid, 1'b1);
    cycle(0, 0, 0, 0, 0, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    cycle(1, 0, 0, 0, 0, 1);
    check("post_rst_valid", out_valid, 1'b0);

    // Randomized traffic.
    repeat (4000) begin
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
